// File: rtl/trade_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | trade_pkg: shared types and widths for the trade order scheduler |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package trade_pkg;

  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    COOLDOWN = 2'd2
  } sched_state_t;

  typedef enum logic {
    SIDE_SELL = 1'b0,
    SIDE_BUY  = 1'b1
  } side_t;

endpackage
`default_nettype wire

// File: rtl/trade_cycle_counter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | trade_cycle_counter: loadable down-counter that parks at zero    |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module trade_cycle_counter
  import trade_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic             zero
);

  logic [CNT_W-1:0] r_count;

  // Holding at zero lets the owner sample the flag on the final cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= load_val;
    end else if (en && (r_count != '0)) begin
      r_count <= r_count - CNT_W'(1);
    end
  end

  assign zero = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/trade_order_scheduler.sv
`default_nettype none
// +------------------------------------------------------------------+
// | trade_order_scheduler: turns buy/sell decisions into single-unit |
// | orders with position limit, cooldown and handshake timeout       |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module trade_order_scheduler
  import trade_pkg::*;
#(
  parameter int  MAX_POS         = 4,
  parameter int  COOLDOWN_CYCLES = 16,
  parameter int  TIMEOUT_CYCLES  = 64,
  localparam int POS_W           = $clog2(MAX_POS + 1) + 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    buy_signal,
  input  logic                    sell_signal,
  input  logic                    order_ready,
  output logic                    order_valid,
  output logic                    order_side,
  output logic signed [POS_W-1:0] position,
  output logic                    busy,
  output logic                    limit_hit,
  output logic                    conflict,
  output logic                    timeout_err
);

  localparam logic signed [POS_W-1:0] c_max_pos = POS_W'(MAX_POS);
  localparam logic signed [POS_W-1:0] c_min_pos = -c_max_pos;
  localparam logic signed [POS_W-1:0] c_one     = POS_W'(1);
  localparam logic [CNT_W-1:0]        c_to_load = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0]        c_cd_load = CNT_W'(COOLDOWN_CYCLES - 1);

  sched_state_t r_state;
  logic         w_start;
  logic         w_limit;
  logic         w_conflict;
  logic         w_issue_done;
  logic         w_to_zero;
  logic         w_cd_zero;

  always_comb begin
    w_start    = 1'b0;
    w_limit    = 1'b0;
    w_conflict = 1'b0;
    if ((r_state == IDLE) && enable) begin
      if (buy_signal && sell_signal) begin
        w_conflict = 1'b1;
      end else if ((buy_signal && (position == c_max_pos)) ||
                   (sell_signal && (position == c_min_pos))) begin
        w_limit = 1'b1;
      end else if (buy_signal || sell_signal) begin
        w_start = 1'b1;
      end
    end
  end

  // A ready on the last timeout cycle still wins: fill takes priority
  assign w_issue_done = (r_state == ISSUE) && (order_ready || w_to_zero);

  trade_cycle_counter u_timeout (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (w_start),
    .load_val (c_to_load),
    .en       (r_state == ISSUE),
    .zero     (w_to_zero)
  );

  trade_cycle_counter u_cooldown (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (w_issue_done),
    .load_val (c_cd_load),
    .en       (r_state == COOLDOWN),
    .zero     (w_cd_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      order_valid <= 1'b0;
      order_side  <= SIDE_SELL;
      position    <= '0;
      busy        <= 1'b0;
      limit_hit   <= 1'b0;
      conflict    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      limit_hit   <= w_limit;
      conflict    <= w_conflict;
      timeout_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_state     <= ISSUE;
            order_valid <= 1'b1;
            order_side  <= buy_signal ? SIDE_BUY : SIDE_SELL;
            busy        <= 1'b1;
          end
        end
        ISSUE: begin
          if (order_ready) begin
            position    <= (order_side == SIDE_BUY) ? position + c_one : position - c_one;
            order_valid <= 1'b0;
            r_state     <= COOLDOWN;
          end else if (w_to_zero) begin
            order_valid <= 1'b0;
            timeout_err <= 1'b1;
            r_state     <= COOLDOWN;
          end
        end
        COOLDOWN: begin
          if (w_cd_zero) begin
            r_state <= IDLE;
            busy    <= 1'b0;
          end
        end
        default: begin
          r_state     <= IDLE;
          order_valid <= 1'b0;
          busy        <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_trade_order_scheduler.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_trade_order_scheduler: directed vector bench for the          |
// | trade order scheduler with default parameters                    |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_trade_order_scheduler;

  localparam int POS_W = 4;

  logic                    clk;
  logic                    rst_n;
  logic                    enable;
  logic                    buy_signal;
  logic                    sell_signal;
  logic                    order_ready;
  logic                    order_valid;
  logic                    order_side;
  logic signed [POS_W-1:0] position;
  logic                    busy;
  logic                    limit_hit;
  logic                    conflict;
  logic                    timeout_err;

  int n_tests;
  int n_fail;

  trade_order_scheduler #(
    .MAX_POS         (4),
    .COOLDOWN_CYCLES (16),
    .TIMEOUT_CYCLES  (64)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .buy_signal  (buy_signal),
    .sell_signal (sell_signal),
    .order_ready (order_ready),
    .order_valid (order_valid),
    .order_side  (order_side),
    .position    (position),
    .busy        (busy),
    .limit_hit   (limit_hit),
    .conflict    (conflict),
    .timeout_err (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic                    en;
    logic                    b;
    logic                    s;
    logic                    r;
    int                      rep;
    logic                    ev;
    logic                    es;
    logic signed [POS_W-1:0] epos;
    logic                    eb;
    logic                    el;
    logic                    ec;
    logic                    et;
  } vec_t;

  vec_t vecs[20];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [9:0] outs();
    return {order_valid, order_side & order_valid, position, busy, limit_hit, conflict, timeout_err};
  endfunction

  initial begin
    n_tests     = 0;
    n_fail      = 0;
    rst_n       = 1'b0;
    enable      = 1'b0;
    buy_signal  = 1'b0;
    sell_signal = 1'b0;
    order_ready = 1'b0;

    //          en    b     s     r    rep  valid side  pos  busy  lim   conf  to
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1,  1'b0, 1'b0, 4'sd0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1,  1'b1, 1'b1, 4'sd0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1,  1'b0, 1'b0, 4'sd1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 1'b1, 1'b0, 1'b1, 14, 1'b0, 1'b0, 4'sd1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1,  1'b0, 1'b0, 4'sd1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1,  1'b0, 1'b0, 4'sd1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1,  1'b1, 1'b1, 4'sd1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 1'b1, 17, 1'b0, 1'b0, 4'sd2, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1,  1'b1, 1'b1, 4'sd2, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 1'b1, 17, 1'b0, 1'b0, 4'sd3, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 1'b1, 1'b0, 1'b1, 1,  1'b1, 1'b1, 4'sd3, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 1'b0, 1'b0, 1'b1, 17, 1'b0, 1'b0, 4'sd4, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{1'b1, 1'b1, 1'b0, 1'b1, 1,  1'b0, 1'b0, 4'sd4, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[13] = '{1'b1, 1'b0, 1'b0, 1'b1, 1,  1'b0, 1'b0, 4'sd4, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[14] = '{1'b1, 1'b0, 1'b1, 1'b1, 1,  1'b1, 1'b0, 4'sd4, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[15] = '{1'b1, 1'b0, 1'b0, 1'b1, 17, 1'b0, 1'b0, 4'sd3, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[16] = '{1'b1, 1'b1, 1'b1, 1'b1, 1,  1'b0, 1'b0, 4'sd3, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[17] = '{1'b1, 1'b0, 1'b0, 1'b1, 1,  1'b0, 1'b0, 4'sd3, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[18] = '{1'b0, 1'b1, 1'b0, 1'b1, 3,  1'b0, 1'b0, 4'sd3, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[19] = '{1'b0, 1'b0, 1'b1, 1'b1, 1,  1'b0, 1'b0, 4'sd3, 1'b0, 1'b0, 1'b0, 1'b0};

    repeat (2) tick();
    chk("reset_outputs", 32'(outs()), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 20; i++) begin
      enable      = vecs[i].en;
      buy_signal  = vecs[i].b;
      sell_signal = vecs[i].s;
      order_ready = vecs[i].r;
      repeat (vecs[i].rep) tick();
      chk($sformatf("vec%0d", i), 32'(outs()),
          32'({vecs[i].ev, vecs[i].es, vecs[i].epos, vecs[i].eb, vecs[i].el, vecs[i].ec, vecs[i].et}));
    end

    // Timeout: valid held 64 cycles, then a single timeout_err pulse
    begin
      int n_valid;
      enable      = 1'b1;
      buy_signal  = 1'b1;
      sell_signal = 1'b0;
      order_ready = 1'b0;
      tick();
      buy_signal = 1'b0;
      n_valid    = 0;
      for (int k = 0; k < 200 && order_valid; k++) begin
        n_valid++;
        tick();
      end
      chk("timeout_valid_cycles", 32'(n_valid), 32'd64);
      chk("timeout_err_pulse", {31'd0, timeout_err}, 32'd1);
      chk("timeout_pos", 32'(position), 32'(4'sd3));
      tick();
      chk("timeout_err_once", {31'd0, timeout_err}, 32'd0);
      repeat (14) tick();
      chk("timeout_cd_busy", {31'd0, busy}, 32'd1);
      tick();
      chk("timeout_cd_idle", {31'd0, busy}, 32'd0);
    end

    // Ready arriving in the final timeout cycle is a fill
    buy_signal = 1'b1;
    tick();
    buy_signal = 1'b0;
    repeat (63) tick();
    chk("lastcycle_valid", {31'd0, order_valid}, 32'd1);
    order_ready = 1'b1;
    tick();
    chk("lastcycle_fill", 32'({order_valid, timeout_err, position}), 32'({1'b0, 1'b0, 4'sd4}));
    order_ready = 1'b0;
    repeat (16) tick();
    chk("lastcycle_idle", {31'd0, busy}, 32'd0);

    // Dropping enable in ISSUE keeps the order alive until ready
    sell_signal = 1'b1;
    tick();
    chk("en_drop_issue", 32'({order_valid, order_side}), 32'b10);
    enable      = 1'b0;
    sell_signal = 1'b0;
    repeat (4) tick();
    chk("en_drop_held", 32'({order_valid, order_side}), 32'b10);
    order_ready = 1'b1;
    tick();
    chk("en_drop_fill", 32'({order_valid, position}), 32'({1'b0, 4'sd3}));
    order_ready = 1'b0;
    enable      = 1'b1;
    repeat (16) tick();
    chk("en_drop_idle", {31'd0, busy}, 32'd0);

    // Asynchronous reset in the middle of an order
    buy_signal = 1'b1;
    tick();
    buy_signal = 1'b0;
    chk("rst_pre_valid", {31'd0, order_valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async", 32'(outs()), 32'd0);
    #3;
    rst_n = 1'b1;
    tick();
    chk("rst_release", 32'(outs()), 32'd0);
    buy_signal = 1'b1;
    tick();
    buy_signal = 1'b0;
    chk("rst_then_buy", 32'(outs()), 32'({1'b1, 1'b1, 4'sd0, 1'b1, 1'b0, 1'b0, 1'b0}));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
